// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads, buffers
// responses in a prefetch FIFO and handles redirects. Optional perf counters: IFETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int                INSTR_W  = 49,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_starve
`endif
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW:0]   CREDIT_C = CW1'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      discard_cnt;
    logic [PW-1:0]      fifo_rd;
    logic [PW-1:0]      fifo_wr;
    logic [PW-1:0]      req_rd;
    logic [PW-1:0]      req_wr;
    logic [INSTR_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc   [DEPTH];
    logic [ADDR_W-1:0]  req_pc    [DEPTH];

    logic [CW:0]        credit_sum;
    logic [CW-1:0]      discard_redir;
    logic               accept;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        credit_sum    = {1'b0, fifo_count} + {1'b0, outstanding};
        mem_req_valid = (state == S_FETCH) && (credit_sum < CREDIT_C) && !redirect_valid;
        mem_req_addr  = fetch_pc;
        accept        = mem_req_valid && mem_req_ready;
        instr_valid   = (fifo_count != '0);
        instr         = instr_valid ? fifo_data[fifo_rd] : '0;
        instr_pc      = instr_valid ? fifo_pc[fifo_rd] : '0;
        do_push       = mem_resp_valid && !redirect_valid && (discard_cnt == '0);
        do_pop        = instr_valid && instr_ready && !redirect_valid;
        // A response landing in the redirect cycle is already one of the discarded ones.
        discard_redir = outstanding - CW'(mem_resp_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            fifo_count  <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            req_rd      <= '0;
            req_wr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(mem_resp_valid);
            req_wr      <= req_wr + PW'(accept);
            req_rd      <= req_rd + PW'(mem_resp_valid);
            if (redirect_valid) begin
                fetch_pc    <= redirect_pc;
                fifo_count  <= '0;
                fifo_rd     <= '0;
                fifo_wr     <= '0;
                discard_cnt <= discard_redir;
                state       <= (discard_redir != '0) ? S_FLUSH : S_FETCH;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 1'b1;
                if (mem_resp_valid && (discard_cnt != '0))
                    discard_cnt <= discard_cnt - 1'b1;
                fifo_count <= fifo_count + CW'(do_push) - CW'(do_pop);
                fifo_wr    <= fifo_wr + PW'(do_push);
                fifo_rd    <= fifo_rd + PW'(do_pop);
                case (state)
                    S_IDLE:  state <= S_FETCH;
                    S_FETCH: state <= S_FETCH;
                    S_FLUSH: begin
                        if ((discard_cnt == '0) || (mem_resp_valid && (discard_cnt == CW'(1))))
                            state <= S_FETCH;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Storage needs no reset: visibility is governed entirely by the counters.
    always_ff @(posedge clk) begin
        if (accept)
            req_pc[req_wr] <= fetch_pc;
        if (do_push) begin
            fifo_data[fifo_wr] <= mem_resp_data;
            fifo_pc[fifo_wr]   <= req_pc[req_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(do_push && (fifo_count == FULL_C) && !do_pop));
            assert (!(mem_resp_valid && (outstanding == '0)));
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [CW:0] amt);
        logic [32:0] s;
        s = {1'b0, v} + 33'(amt);
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [CW:0] flush_amt;

    always_comb begin
        if (redirect_valid)
            flush_amt = {1'b0, fifo_count} + CW1'(mem_resp_valid);
        else
            flush_amt = CW1'(mem_resp_valid && (discard_cnt != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_starve  <= '0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, CW1'(accept));
            perf_flushed <= sat_add(perf_flushed, flush_amt);
            perf_starve  <= sat_add(perf_starve, CW1'(instr_ready && !instr_valid));
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit: in-order memory model with random delay,
// scoreboard of expected {pc,data} pushed at request acceptance and popped at decoder consume.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h10;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [48:0] mem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [48:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch_unit #(.INSTR_W(49), .ADDR_W(32), .DEPTH(2), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] popq[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int pops = 0;
    int stale = 0;
    int last_due = 0;
    int k_ready = 100, k_iready = 100, k_dmin = 1, k_dmax = 1;
    bit do_redirect = 0, redir_on_resp = 0;
    logic [31:0] redir_target = '0;
    logic [31:0] exp_pc = RPC;
    bit first_after_reset = 0, prev_redirect = 0, prev_stall = 0, prev_hold = 0;
    logic [31:0] prev_addr = '0, prev_ipc = '0;
    logic [48:0] prev_instr = '0;
    bit measure = 0;
    int first_acc = -1, first_val = -1;
    int budget;

    function automatic logic [48:0] mdata(input logic [31:0] a);
        return {a[16:0], ~a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic cycle();
        int    stale_before;
        int    d;
        int    due;
        bit    had_resp;
        stale_before = stale;
        had_resp = 0;
        rst = 1'b0;
        mem_req_ready = (int'($urandom_range(99)) < k_ready);
        instr_ready = (int'($urandom_range(99)) < k_iready);
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = mdata(pend[0].addr);
            void'(pend.pop_front());
            had_resp = 1;
            if (stale > 0) stale--;
        end
        redirect_valid = do_redirect || (redir_on_resp && had_resp);
        redirect_pc = redirect_valid ? redir_target : '0;
        if (redirect_valid) begin
            do_redirect = 0;
            redir_on_resp = 0;
        end
        #1;
        if (first_after_reset) check("idle_no_req", 64'(mem_req_valid), 64'(0));
        if (stale_before > 0) check("flush_block", 64'(mem_req_valid), 64'(0));
        if (prev_redirect) check("redir_empty", 64'(instr_valid), 64'(0));
        if (prev_stall && !redirect_valid) begin
            check("req_hold_valid", 64'(mem_req_valid), 64'(1));
            check("req_hold_addr", 64'(mem_req_addr), 64'(prev_addr));
        end
        if (prev_hold) begin
            check("head_hold_valid", 64'(instr_valid), 64'(1));
            check("head_hold_pc", 64'(instr_pc), 64'(prev_ipc));
            check("head_hold_data", 64'(instr), 64'(prev_instr));
        end
        if (measure && first_val < 0 && instr_valid) first_val = cyc;
        if (mem_req_valid && mem_req_ready) begin
            if (measure && first_acc < 0) first_acc = cyc;
            check("req_addr", 64'(mem_req_addr), 64'(exp_pc));
            d = int'($urandom_range(k_dmax, k_dmin));
            due = cyc + d;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: mem_req_addr, due: due});
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd1;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 64'(instr_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("pop_pc", 64'(instr_pc), 64'(exp_q[0]));
                check("pop_data", 64'(instr), 64'(mdata(exp_q[0])));
                void'(exp_q.pop_front());
            end
            popq.push_back(instr_pc);
            pops++;
        end
        if (redirect_valid) begin
            stale = pend.size();
            exp_q.delete();
            popq.delete();
            exp_pc = redirect_pc;
        end
        prev_redirect = redirect_valid;
        prev_stall = mem_req_valid && !mem_req_ready && !redirect_valid;
        prev_addr = mem_req_addr;
        prev_hold = instr_valid && !instr_ready && !redirect_valid;
        prev_ipc = instr_pc;
        prev_instr = instr;
        first_after_reset = 0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_req_addr", 64'(mem_req_addr), 64'(RPC));
        check("rst_instr_valid", 64'(instr_valid), 64'(0));
        check("rst_instr", 64'(instr), 64'(0));
        check("rst_instr_pc", 64'(instr_pc), 64'(0));
        pend.delete();
        exp_q.delete();
        popq.delete();
        stale = 0;
        last_due = 0;
        exp_pc = RPC;
        do_redirect = 0;
        redir_on_resp = 0;
        prev_redirect = 0;
        prev_stall = 0;
        prev_hold = 0;
        first_after_reset = 1;
    endtask

    task automatic run_pops(input string tag, input int n, input int limit);
        int target;
        int k;
        target = pops + n;
        k = 0;
        while (pops < target && k < limit) begin
            cycle();
            k++;
        end
        check(tag, 64'(pops >= target), 64'(1));
    endtask

    initial begin
        rst = 1'b1;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);

        // Reset, then streaming from RESET_PC with 1-cycle memory
        do_reset(3);
        measure = 1;
        run_pops("t1_timeout", 3, 50);
        measure = 0;
        check("t1_latency", 64'(first_val - first_acc), 64'(2));
        check("t1_pc0", 64'(popq[0]), 64'(32'h10));
        check("t1_pc2", 64'(popq[2]), 64'(32'h12));

        // Decoder stall for 10 cycles
        k_iready = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t2_credit", 64'(exp_q.size() <= 2), 64'(1));
        end
        check("t2_req_blocked", 64'(mem_req_valid), 64'(0));
        check("t2_head_valid", 64'(instr_valid), 64'(1));
        check("t2_buffered", 64'(exp_q.size()), 64'(2));
        k_iready = 100;
        run_pops("t2_timeout", 6, 60);

        // Redirect with two requests outstanding
        k_dmin = 4;
        k_dmax = 4;
        budget = 0;
        while (!(pend.size() == 2 && pend[0].due > cyc) && budget < 60) begin
            cycle();
            budget++;
        end
        check("t3_setup", 64'(pend.size()), 64'(2));
        do_redirect = 1;
        redir_target = 32'h40;
        cycle();
        check("t3_flush_entered", 64'(stale), 64'(2));
        budget = 0;
        while (stale > 0 && budget < 20) begin
            cycle();
            budget++;
        end
        check("t3_flush_exit", 64'(mem_req_valid), 64'(1));
        run_pops("t3_timeout", 3, 60);
        check("t3_target", 64'(popq[0]), 64'(32'h40));

        // Redirect coinciding with a response and a ready decoder
        k_dmin = 2;
        k_dmax = 2;
        run_pops("t4_warm", 3, 40);
        redir_on_resp = 1;
        redir_target = 32'h80;
        budget = 0;
        while (redir_on_resp && budget < 20) begin
            cycle();
            budget++;
        end
        check("t4_fired", 64'(redir_on_resp), 64'(0));
        run_pops("t4_timeout", 3, 60);
        check("t4_target", 64'(popq[0]), 64'(32'h80));

        // Random backpressure and response delay
        k_ready = 30;
        k_dmin = 1;
        k_dmax = 4;
        k_iready = 70;
        run_pops("t5_timeout", 1000, 40000);

        // PC wrap
        k_ready = 100;
        k_dmin = 1;
        k_dmax = 1;
        k_iready = 100;
        do_redirect = 1;
        redir_target = 32'hFFFF_FFFE;
        cycle();
        run_pops("t6_timeout", 3, 60);
        check("t6_pc0", 64'(popq[0]), 64'(32'hFFFF_FFFE));
        check("t6_pc1", 64'(popq[1]), 64'(32'hFFFF_FFFF));
        check("t6_wrap", 64'(popq[2]), 64'(32'h0000_0000));

        // Reset mid-stream
        k_ready = 60;
        k_dmin = 1;
        k_dmax = 3;
        for (int i = 0; i < 7; i++) cycle();
        do_reset(1);
        k_ready = 100;
        k_dmin = 1;
        k_dmax = 1;
        run_pops("t7_timeout", 3, 50);
        check("t7_restart_pc", 64'(popq[0]), 64'(RPC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word-addressed reads to instruction memory using a valid/ready request channel and an in-order response channel.
- Buffers returned 49-bit instructions in a small prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Handles branch redirects from execute by flushing the FIFO and discarding in-flight responses.

Parameters:
- INSTR_W, 49: instruction width; op[48:44], mode[43:42], src[41:37], dst[36:32], lit[31:0].
- ADDR_W, 32: PC / memory word-address width.
- DEPTH, 2: prefetch FIFO entries; also the maximum outstanding-plus-buffered credit (power of 2, ≥2).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Synchronous, active-high reset.
- mem_req_valid  out  1  Fetch request valid.
- mem_req_ready  in  1  Memory accepts the request.
- mem_req_addr  out  ADDR_W  Word address requested.
- mem_resp_valid  in  1  Response data valid, in request order; there is no backpressure on this channel.
- mem_resp_data  in  INSTR_W  Returned instruction word.
- instr_valid  out  1  FIFO head is valid for the decoder.
- instr_ready  in  1  Decoder consumes the head.
- instr  out  INSTR_W  FIFO head instruction.
- instr_pc  out  ADDR_W  Address of the head instruction.
- redirect_valid  in  1  Taken branch from execute.
- redirect_pc  in  ADDR_W  Branch target.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard_cnt=0; state=IDLE.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - Reset asserted mid-operation abandons all in-flight requests. The memory is reset alongside, so responses are not tracked across reset.
- State machine:
  - IDLE: one cycle after reset release, then go to FETCH.
  - FETCH: normal issue.
  - FLUSH: entered on redirect when the post-redirect discard_cnt>0. Requests are blocked. Return to FETCH in the cycle discard_cnt reaches 0.
- Issue:
  - In FETCH, mem_req_valid=1 iff (fifo_count + outstanding) < DEPTH and redirect_valid=0.
  - mem_req_addr=fetch_pc.
  - On mem_req_valid&&mem_req_ready: fetch_pc+=1 (wraps modulo 2^ADDR_W); outstanding+=1.
  - mem_req_addr must hold stable while mem_req_valid=1 and mem_req_ready=0.
- Response:
  - On mem_resp_valid: outstanding-=1.
  - If discard_cnt>0, drop the data and decrement discard_cnt. Otherwise push {data, pc} into the FIFO.
  - The pushed pc comes from a per-slot PC recorded at request time.
- Credit rule: the FIFO never overflows, because issue is credit-limited.
  - A push into a full FIFO is an assertion failure.
  - A response with outstanding=0 is an assertion failure.
- Output:
  - instr_valid = FIFO non-empty; instr and instr_pc show the head.
  - Pop on instr_valid&&instr_ready.
  - Simultaneous push and pop is legal at any occupancy, including full (pop first) and empty (data not visible until the next cycle; no bypass).
  - Head data holds stable while instr_valid=1 and instr_ready=0.
- Redirect: redirect_valid has priority over every other event in that cycle.
  - FIFO cleared, so instr_valid=0 next cycle.
  - A pop in the same cycle is ignored.
  - fetch_pc=redirect_pc.
  - discard_cnt = outstanding − (mem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
  - A redirect while in FLUSH reloads fetch_pc and keeps counting discards as above.
- Counters are sized to clog2(DEPTH)+1 bits.
- Latency: minimum of 2 cycles from request acceptance to instr_valid when memory responds on the next cycle.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- Defined: adds three outputs, all reset to 0 and saturating at all-ones:
  - perf_fetched (32 bits): requests accepted.
  - perf_flushed (32 bits): FIFO entries plus responses discarded by redirects.
  - perf_starve (32 bits): cycles with instr_ready=1 and instr_valid=0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x10, memory ready always and 1-cycle response:
  - Requests go to 0x10, 0x11, ….
  - instr_valid first rises 2 cycles after the first accept.
  - instr_pc sequence is 0x10, 0x11, 0x12 with matching data.
- instr_ready held 0 for 10 cycles:
  - At most DEPTH=2 requests are outstanding or buffered; mem_req_valid drops.
  - Head instr is stable; on release, no instruction is lost or duplicated.
- redirect_valid with redirect_pc=0x40 while 2 requests are outstanding:
  - FIFO empties; both late responses are dropped; state passes through FLUSH.
  - Next instr_pc=0x40.
- Redirect in the same cycle as mem_resp_valid and instr_ready=1:
  - Response dropped; discard_cnt=outstanding−1; no pop is counted.
  - First post-redirect instruction is at the target.
- mem_req_ready random at 30%, response delay random 1–4 cycles (in order):
  - Scoreboard confirms decoder receives a consecutive PC stream with no gaps or duplicates over 1000 instructions.
- fetch_pc=0xFFFFFFFF: next request address wraps to 0x00000000. Reset asserted mid-stream: all outputs return to their reset values the next cycle.
